// File: rtl/nand_seq_alu_if.sv
// Command/result handshake bundle for nand_seq_alu.
// master drives commands and accepts results; slave is the ALU.
interface nand_seq_alu_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             busy;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, busy
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, busy
    );
endinterface

// File: rtl/nand_seq_alu.sv
// Multi-cycle bitwise logic unit built from a single shared WIDTH-bit NAND stage.
// Optional NAND_SEQ_STATS_EN adds saturating pass_count/cmd_count outputs.
module nand_seq_alu #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    nand_seq_alu_if.slave      bus
`ifdef NAND_SEQ_STATS_EN
    ,
    output logic [15:0]        pass_count,
    output logic [15:0]        cmd_count
`endif
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned STEP_W = 3;

    localparam logic [OP_W-1:0] OP_NAND = 3'd0;
    localparam logic [OP_W-1:0] OP_AND  = 3'd1;
    localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
    localparam logic [OP_W-1:0] OP_OR   = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
    localparam logic [OP_W-1:0] OP_BUF  = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [2:0] {SRC_A, SRC_B, SRC_T, SRC_U, SRC_V, SRC_Y} src_t;
    typedef enum logic [1:0] {DST_T, DST_U, DST_V, DST_Y} dst_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [OP_W-1:0]   r_op;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_t;
    logic [WIDTH-1:0]  r_u;
    logic [WIDTH-1:0]  r_v;
    logic [WIDTH-1:0]  r_y;
    logic [STEP_W-1:0] r_step;

    logic              w_accept;
    logic              w_exec;
    src_t              w_sel_x;
    src_t              w_sel_z;
    dst_t              w_dst;
    logic              w_last;
    logic [WIDTH-1:0]  w_x;
    logic [WIDTH-1:0]  w_z;
    logic [WIDTH-1:0]  w_nand;

    // NAND schedule: operand selects and destination for each (op, step)
    always_comb begin
        w_sel_x = SRC_A;
        w_sel_z = SRC_A;
        w_dst   = DST_Y;
        w_last  = 1'b1;
        case (r_op)
            OP_NAND: begin
                w_sel_x = SRC_A; w_sel_z = SRC_B; w_dst = DST_Y;
            end
            OP_AND, OP_BUF: begin
                if (r_step == STEP_W'(0)) begin
                    w_sel_x = SRC_A;
                    w_sel_z = (r_op == OP_AND) ? SRC_B : SRC_A;
                    w_dst   = DST_T;
                    w_last  = 1'b0;
                end else begin
                    w_sel_x = SRC_T; w_sel_z = SRC_T; w_dst = DST_Y;
                end
            end
            OP_NOT: begin
                w_sel_x = SRC_A; w_sel_z = SRC_A; w_dst = DST_Y;
            end
            OP_OR, OP_NOR: begin
                w_last = 1'b0;
                case (r_step)
                    STEP_W'(0): begin w_sel_x = SRC_A; w_sel_z = SRC_A; w_dst = DST_T; end
                    STEP_W'(1): begin w_sel_x = SRC_B; w_sel_z = SRC_B; w_dst = DST_U; end
                    STEP_W'(2): begin
                        w_sel_x = SRC_T; w_sel_z = SRC_U; w_dst = DST_Y;
                        w_last  = (r_op == OP_OR);
                    end
                    default: begin w_sel_x = SRC_Y; w_sel_z = SRC_Y; w_dst = DST_Y; w_last = 1'b1; end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                w_last = 1'b0;
                case (r_step)
                    STEP_W'(0): begin w_sel_x = SRC_A; w_sel_z = SRC_B; w_dst = DST_T; end
                    STEP_W'(1): begin w_sel_x = SRC_A; w_sel_z = SRC_T; w_dst = DST_U; end
                    STEP_W'(2): begin w_sel_x = SRC_B; w_sel_z = SRC_T; w_dst = DST_V; end
                    STEP_W'(3): begin
                        w_sel_x = SRC_U; w_sel_z = SRC_V; w_dst = DST_Y;
                        w_last  = (r_op == OP_XOR);
                    end
                    default: begin w_sel_x = SRC_Y; w_sel_z = SRC_Y; w_dst = DST_Y; w_last = 1'b1; end
                endcase
            end
            default: begin
                w_sel_x = SRC_A; w_sel_z = SRC_A; w_dst = DST_Y;
            end
        endcase
    end

    // Operand muxes feeding the single NAND stage
    always_comb begin
        w_x = r_a;
        w_z = r_a;
        case (w_sel_x)
            SRC_A:   w_x = r_a;
            SRC_B:   w_x = r_b;
            SRC_T:   w_x = r_t;
            SRC_U:   w_x = r_u;
            SRC_V:   w_x = r_v;
            default: w_x = r_y;
        endcase
        case (w_sel_z)
            SRC_A:   w_z = r_a;
            SRC_B:   w_z = r_b;
            SRC_T:   w_z = r_t;
            SRC_U:   w_z = r_u;
            SRC_V:   w_z = r_v;
            default: w_z = r_y;
        endcase
    end

    assign w_nand = ~(w_x & w_z);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_exec      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_exec = 1'b1;
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_t    <= '0;
            r_u    <= '0;
            r_v    <= '0;
            r_y    <= '0;
            r_step <= '0;
        end else if (w_accept) begin
            r_op   <= bus.op;
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_step <= '0;
        end else if (w_exec) begin
            r_step <= r_step + STEP_W'(1);
            case (w_dst)
                DST_T:   r_t <= w_nand;
                DST_U:   r_u <= w_nand;
                DST_V:   r_v <= w_nand;
                default: r_y <= w_nand;
            endcase
        end
    end

`ifdef NAND_SEQ_STATS_EN
    logic [15:0] r_pass_count;
    logic [15:0] r_cmd_count;

    // Saturating activity counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pass_count <= '0;
            r_cmd_count  <= '0;
        end else begin
            if (w_exec && (r_pass_count != 16'hFFFF)) r_pass_count <= r_pass_count + 16'd1;
            if (w_accept && (r_cmd_count != 16'hFFFF)) r_cmd_count <= r_cmd_count + 16'd1;
        end
    end

    assign pass_count = r_pass_count;
    assign cmd_count  = r_cmd_count;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.y         = r_y;

endmodule

// File: tb/tb_nand_seq_alu.sv
// Self-checking bench for nand_seq_alu: op table, backpressure, operand change, mid-op reset.
module tb_nand_seq_alu;
    localparam int unsigned WIDTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nand_seq_alu_if #(.WIDTH(WIDTH)) bus ();

`ifdef NAND_SEQ_STATS_EN
    logic [15:0] pass_count;
    logic [15:0] cmd_count;
`endif

    nand_seq_alu #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
`ifdef NAND_SEQ_STATS_EN
        ,
        .pass_count (pass_count),
        .cmd_count  (cmd_count)
`endif
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_y;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic [7:0] y;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return ~(a & b);
            3'd1:    return a & b;
            3'd2:    return ~a;
            3'd3:    return a | b;
            3'd4:    return ~(a | b);
            3'd5:    return a ^ b;
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        case (op)
            3'd0:    return 1;
            3'd1:    return 2;
            3'd2:    return 1;
            3'd3:    return 3;
            3'd4:    return 4;
            3'd5:    return 4;
            3'd6:    return 5;
            default: return 2;
        endcase
    endfunction

    // One command with out_ready held high; optionally scrambles inputs after accept
    task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_y, input int exp_lat, input bit scramble,
                          input string tag);
        exp_t e;
        exp_t g;
        int   lat;
        bit   seen;
        e.y   = exp_y;
        e.lat = exp_lat;
        @(negedge clk);
        check({tag, " in_ready before"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check({tag, " busy after accept"}, 32'(bus.busy), 32'd1);
        if (scramble) begin
            bus.a  = 8'($urandom);
            bus.b  = 8'($urandom);
            bus.op = 3'($urandom);
        end
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) seen = 1'b1;
        end
        check({tag, " out_valid seen"}, 32'(seen), 32'd1);
        g = sb.pop_front();
        if (seen) begin
            check({tag, " y"}, 32'(bus.y), 32'(g.y));
            check({tag, " latency"}, 32'(lat), 32'(g.lat));
        end
        @(posedge clk);
        #1;
        check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
        check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   lat;
        bit   seen;
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;

        vecs[0] = '{3'd0, 8'hA5, 8'h0F, 8'hFA, 1};
        vecs[1] = '{3'd1, 8'hA5, 8'h0F, 8'h05, 2};
        vecs[2] = '{3'd2, 8'hA5, 8'h0F, 8'h5A, 1};
        vecs[3] = '{3'd3, 8'hA5, 8'h0F, 8'hAF, 3};
        vecs[4] = '{3'd4, 8'hA5, 8'h0F, 8'h50, 4};
        vecs[5] = '{3'd5, 8'hA5, 8'h0F, 8'hAA, 4};
        vecs[6] = '{3'd6, 8'hA5, 8'h0F, 8'h55, 5};
        vecs[7] = '{3'd7, 8'hA5, 8'h0F, 8'hA5, 2};

        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset y", 32'(bus.y), 32'h00);
        rst_n = 1'b1;

        // Op sweep from the table
        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_y, vecs[i].exp_lat, 1'b0,
                   $sformatf("op%0d", vecs[i].op));

`ifdef NAND_SEQ_STATS_EN
        check("stats pass_count", 32'(pass_count), 32'd22);
        check("stats cmd_count", 32'(cmd_count), 32'd8);
`endif

        // Backpressure on XOR FF^00
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = 3'd5;
        bus.a         = 8'hFF;
        bus.b         = 8'h00;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.op = 3'd0;
        bus.a  = 8'h00;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus.out_valid) seen = 1'b1;
        end
        check("bp out_valid seen", 32'(seen), 32'd1);
        check("bp latency", 32'(lat), 32'd4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold%0d out_valid", i), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp hold%0d y", i), 32'(bus.y), 32'hFF);
            check($sformatf("bp hold%0d in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        check("bp release out_valid", 32'(bus.out_valid), 32'd0);
        check("bp release busy", 32'(bus.busy), 32'd0);

        // Operands change right after accept
        run_op(3'd4, 8'h3C, 8'h0F, model(3'd4, 8'h3C, 8'h0F), model_lat(3'd4), 1'b1, "opchg nor");
        run_op(3'd6, 8'hC3, 8'h99, model(3'd6, 8'hC3, 8'h99), model_lat(3'd6), 1'b1, "opchg xnor");

        // Mid-op reset during XNOR
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.op        = 3'd6;
        bus.a         = 8'h5A;
        bus.b         = 8'h3C;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst busy", 32'(bus.busy), 32'd0);
        check("midrst y", 32'(bus.y), 32'h00);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("midrst no out_valid", 32'(seen), 32'd0);
        run_op(3'd0, 8'h00, 8'h00, 8'hFF, 1, 1'b0, "postrst nand");

        // Random commands against the behavioural model
        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom);
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            run_op(rop, ra, rb, model(rop, ra, rb), model_lat(rop), 1'b1,
                   $sformatf("rand%0d op%0d", i, rop));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
